// File: rtl/att_dot_sequencer.sv
// Attention dot-product microkernel controller: stages Q/K word pairs, runs a
// multi-cycle INT8 dot product, applies scale/shift/clip and answers each RUN.
module att_dot_sequencer #(
  parameter int MaxK    = 256,
  parameter int IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3:0]         issue_opcode_i,
  input  logic [31:0]        issue_rs1_i,
  input  logic [31:0]        issue_rs2_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [31:0]        result_data_o,
  output logic [IdWidth-1:0] result_id_o,
  output logic               illegal_o,
  output logic               cfg_err_o,
  output logic               busy_o
);

  localparam int MaxWords = MaxK / 4;
  localparam int IdxW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;
  localparam int KwW      = $clog2(MaxWords + 1);

  typedef enum logic [3:0] {
    OP_SETUP     = 4'b1000,
    OP_RUN       = 4'b1001,
    OP_RUN_SCALE = 4'b1010,
    OP_RUN_CLIP  = 4'b1011
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_POST    = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_RUN   = 2'd0,
    M_SCALE = 2'd1,
    M_CLIP  = 2'd2
  } mode_t;

  // K=0 selects the full buffer; K below one word still runs a single word.
  function automatic logic [KwW-1:0] k_words_of(input logic [7:0] k);
    if (k == 8'd0) begin
      return KwW'(MaxWords);
    end else if (k < 8'd4) begin
      return KwW'(1'b1);
    end else begin
      return KwW'(k >> 2);
    end
  endfunction

  function automatic mode_t mode_of(input logic [3:0] op);
    case (op)
      OP_RUN_SCALE: return M_SCALE;
      OP_RUN_CLIP:  return M_CLIP;
      default:      return M_RUN;
    endcase
  endfunction

  function automatic logic signed [31:0] dot4(input logic [31:0] q, input logic [31:0] k);
    logic signed [31:0] sum;
    logic signed [7:0]  qa;
    logic signed [7:0]  ka;
    sum = 32'sd0;
    for (int i = 0; i < 4; i++) begin
      qa  = q[8*i +: 8];
      ka  = k[8*i +: 8];
      sum = sum + qa * ka;
    end
    return sum;
  endfunction

  // Q8.8 scale, then a flooring arithmetic shift by 8+shift; clip saturates to int16.
  function automatic logic [31:0] post_op(input mode_t mode, input logic signed [31:0] acc,
                                          input logic signed [15:0] scale, input logic [3:0] shift);
    logic signed [47:0] prod;
    logic signed [47:0] shifted;
    logic signed [31:0] scaled;
    prod    = acc * scale;
    shifted = prod >>> (5'd8 + 5'(shift));
    scaled  = shifted[31:0];
    case (mode)
      M_RUN:   return acc;
      M_SCALE: return scaled;
      M_CLIP: begin
        if (scaled > 32'sd32767) begin
          return 32'h0000_7FFF;
        end else if (scaled < -32'sd32768) begin
          return 32'hFFFF_8000;
        end else begin
          return scaled;
        end
      end
      default: return acc;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [IdxW-1:0]     stage_q, stage_d;
  logic [IdxW-1:0]     word_q, word_d;
  logic [KwW-1:0]      k_words_q, k_words_d;
  logic signed [15:0]  scale_q, scale_d;
  logic [3:0]          shift_q, shift_d;
  logic                cfg_err_q, cfg_err_d;
  mode_t               mode_q, mode_d;
  logic signed [31:0]  acc_q, acc_d;
  logic [31:0]         data_q, data_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic                valid_q, valid_d;
  logic                illegal_q, illegal_d;
  logic                busy_q, busy_d;

  logic [63:0]         pair_mem [MaxWords];
  logic                buf_we_s;
  logic                issue_fire_s;
  logic [KwW-1:0]      stage_next_s;
  logic                last_word_s;
  logic [63:0]         pair_rd_s;

  assign issue_ready_o  = (state_q == S_IDLE);
  assign issue_fire_s   = issue_valid_i && issue_ready_o;
  assign stage_next_s   = KwW'(stage_q) + KwW'(1'b1);
  assign last_word_s    = ((KwW'(word_q) + KwW'(1'b1)) == k_words_q);
  assign pair_rd_s      = pair_mem[word_q];

  assign result_valid_o = valid_q;
  assign result_data_o  = data_q;
  assign result_id_o    = id_q;
  assign illegal_o      = illegal_q;
  assign cfg_err_o      = cfg_err_q;
  assign busy_o         = busy_q;

  // Next-state and datapath decode for the issue/compute/respond sequence.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    word_d    = word_q;
    k_words_d = k_words_q;
    scale_d   = scale_q;
    shift_d   = shift_q;
    cfg_err_d = cfg_err_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    data_d    = data_q;
    id_d      = id_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    buf_we_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (issue_fire_s) begin
          case (issue_opcode_i)
            OP_SETUP: begin
              k_words_d = k_words_of(issue_rs1_i[7:0]);
              shift_d   = issue_rs1_i[11:8];
              scale_d   = issue_rs2_i[15:0];
              cfg_err_d = (issue_rs1_i[7:0] != 8'd0) &&
                          ((issue_rs1_i[1:0] != 2'b00) || (issue_rs1_i[7:0] < 8'd4));
              stage_d   = {IdxW{1'b0}};
            end
            OP_RUN, OP_RUN_SCALE, OP_RUN_CLIP: begin
              buf_we_s = 1'b1;
              id_d     = issue_id_i;
              if (stage_next_s < k_words_q) begin
                stage_d = stage_q + IdxW'(1'b1);
                data_d  = 32'd0;
                valid_d = 1'b1;
                state_d = S_RESP;
              end else begin
                stage_d = {IdxW{1'b0}};
                word_d  = {IdxW{1'b0}};
                mode_d  = mode_of(issue_opcode_i);
                acc_d   = 32'sd0;
                state_d = S_COMPUTE;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_q + dot4(pair_rd_s[63:32], pair_rd_s[31:0]);
        if (last_word_s) begin
          word_d  = {IdxW{1'b0}};
          state_d = S_POST;
        end else begin
          word_d  = word_q + IdxW'(1'b1);
        end
      end
      S_POST: begin
        data_d  = post_op(mode_q, acc_q, scale_q, shift_q);
        valid_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (stage_d != {IdxW{1'b0}});
  end

  // Control, configuration and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      stage_q   <= {IdxW{1'b0}};
      word_q    <= {IdxW{1'b0}};
      k_words_q <= KwW'(1'b1);
      scale_q   <= 16'sh0100;
      shift_q   <= 4'd0;
      cfg_err_q <= 1'b0;
      mode_q    <= M_RUN;
      acc_q     <= 32'sd0;
      data_q    <= 32'd0;
      id_q      <= {IdWidth{1'b0}};
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      word_q    <= word_d;
      k_words_q <= k_words_d;
      scale_q   <= scale_d;
      shift_q   <= shift_d;
      cfg_err_q <= cfg_err_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  // Staging buffer; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (buf_we_s) begin
      pair_mem[stage_q] <= {issue_rs1_i, issue_rs2_i};
    end
  end

endmodule

// File: tb/tb_att_dot_sequencer.sv
// Self-checking bench for att_dot_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against an arithmetic reference model.
module tb_att_dot_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  issue_opcode_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic [3:0]  issue_id_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_data_o;
  logic [3:0]  result_id_o;
  logic        illegal_o;
  logic        cfg_err_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  att_dot_sequencer #(.MaxK(256), .IdWidth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_opcode_i(issue_opcode_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i), .issue_id_i(issue_id_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_id_o(result_id_o),
    .illegal_o(illegal_o), .cfg_err_o(cfg_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [3:0] SETUP = 4'b1000, RUN = 4'b1001, RSC = 4'b1010, RCL = 4'b1011;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  id;
    logic        resp;
    logic [31:0] data;
    int          lat;
    logic        cfg;
  } vec_t;

  // Reference model state
  int          m_kw;
  int          m_scale;
  int          m_shift;
  logic [63:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    issue_valid_i = 1'b0;
    result_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    m_kw = 1; m_scale = 256; m_shift = 0;
    m_pend.delete();
  endtask

  // Issue one instruction; returns at the falling edge of cycle T+1.
  task automatic send(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [3:0] id);
    chk("issue_ready", {31'd0, issue_ready_o}, 32'd1);
    issue_valid_i = 1'b1; issue_opcode_i = op;
    issue_rs1_i = rs1; issue_rs2_i = rs2; issue_id_i = id;
    @(posedge clk_i);
    @(negedge clk_i);
    issue_valid_i = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] data, input logic [3:0] id,
                             input int lat, input int hold);
    int cnt = 0;
    while (!result_valid_o && cnt < 300) begin
      @(negedge clk_i);
      cnt++;
    end
    chk({name, "_lat"}, cnt, lat);
    chk({name, "_data"}, result_data_o, data);
    chk({name, "_id"}, {28'd0, result_id_o}, {28'd0, id});
    repeat (hold) @(negedge clk_i);
    result_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    result_ready_i = 1'b0;
    chk({name, "_drop"}, {31'd0, result_valid_o}, 32'd0);
  endtask

  function automatic logic [31:0] ref_value(input logic [3:0] op);
    longint acc, p, d, v;
    byte a, b;
    acc = 0;
    foreach (m_pend[j]) begin
      for (int i = 0; i < 4; i++) begin
        a = m_pend[j][32 + 8*i +: 8];
        b = m_pend[j][8*i +: 8];
        acc += a * b;
      end
    end
    if (op == RUN) return acc[31:0];
    p = acc * m_scale;
    d = longint'(1) << (8 + m_shift);
    v = p / d;
    if ((p % d != 0) && (p < 0)) v = v - 1;
    if (op == RCL) begin
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
    end
    return v[31:0];
  endfunction

  task automatic m_setup(input logic [31:0] rs1, input logic [31:0] rs2);
    int k;
    shortint s16;
    k = rs1[7:0];
    send(SETUP, rs1, rs2, 4'h0);
    m_kw = (k == 0) ? 64 : ((k < 4) ? 1 : (k / 4));
    m_shift = rs1[11:8];
    s16 = rs2[15:0];
    m_scale = s16;
    m_pend.delete();
    chk("m_cfg_err", {31'd0, cfg_err_o}, {31'd0, (k != 0) && ((k % 4 != 0) || (k < 4))});
    chk("m_busy_setup", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic m_run(input logic [3:0] op, input logic [31:0] q, input logic [31:0] k,
                       input logic [3:0] id, input int hold);
    logic [31:0] exp;
    int lat;
    m_pend.push_back({q, k});
    if (m_pend.size() < m_kw) begin
      exp = 32'd0;
      lat = 0;
    end else begin
      exp = ref_value(op);
      lat = m_kw + 1;
      m_pend.delete();
    end
    send(op, q, k, id);
    expect_resp("m_run", exp, id, lat, hold);
    chk("m_busy_run", {31'd0, busy_o}, {31'd0, m_pend.size() != 0});
  endtask

  initial begin
    vec_t vecs[21];
    logic seen;
    vecs[0]  = '{RUN,   32'h01020304, 32'h01010101, 4'h3, 1'b1, 32'd10,       2, 1'b0};
    vecs[1]  = '{SETUP, 32'h00000008, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[2]  = '{RUN,   32'h7F7F7F7F, 32'h7F7F7F7F, 4'h5, 1'b1, 32'd0,        0, 1'b0};
    vecs[3]  = '{RUN,   32'h80808080, 32'h80808080, 4'h6, 1'b1, 32'd130052,   3, 1'b0};
    vecs[4]  = '{SETUP, 32'h00000104, 32'h00000080, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[5]  = '{RSC,   32'h0A0A0A0A, 32'h0A0A0A0A, 4'h7, 1'b1, 32'd100,      2, 1'b0};
    vecs[6]  = '{SETUP, 32'h00000004, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[7]  = '{RCL,   32'h7F7F7F7F, 32'h7F7F7F7F, 4'h8, 1'b1, 32'd32767,    2, 1'b0};
    vecs[8]  = '{RCL,   32'h80808080, 32'h7F7F7F7F, 4'h9, 1'b1, 32'hFFFF8000, 2, 1'b0};
    vecs[9]  = '{RUN,   32'h80808080, 32'h7F7F7F7F, 4'hA, 1'b1, 32'hFFFF0200, 2, 1'b0};
    vecs[10] = '{SETUP, 32'h00000004, 32'h0000FF00, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[11] = '{RSC,   32'h01020304, 32'h01010101, 4'hB, 1'b1, 32'hFFFFFFF6, 2, 1'b0};
    vecs[12] = '{SETUP, 32'h00000204, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[13] = '{RSC,   32'h000000FD, 32'h00000001, 4'hC, 1'b1, 32'hFFFFFFFF, 2, 1'b0};
    vecs[14] = '{SETUP, 32'h00000006, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b1};
    vecs[15] = '{RUN,   32'h01020304, 32'h01010101, 4'hD, 1'b1, 32'd10,       2, 1'b1};
    vecs[16] = '{SETUP, 32'h00000002, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b1};
    vecs[17] = '{SETUP, 32'h0000000C, 32'h00000100, 4'h0, 1'b0, 32'd0,        0, 1'b0};
    vecs[18] = '{RUN,   32'h01010101, 32'h02020202, 4'h1, 1'b1, 32'd0,        0, 1'b0};
    vecs[19] = '{RUN,   32'h01010101, 32'h02020202, 4'h2, 1'b1, 32'd0,        0, 1'b0};
    vecs[20] = '{RUN,   32'h01010101, 32'hFFFFFFFF, 4'hE, 1'b1, 32'd12,       4, 1'b0};

    rst_i = 1'b1; issue_valid_i = 1'b0; result_ready_i = 1'b0;
    issue_opcode_i = 4'h0; issue_rs1_i = 32'd0; issue_rs2_i = 32'd0; issue_id_i = 4'h0;
    do_reset();
    chk("rst_data", result_data_o, 32'd0);
    chk("rst_id", {28'd0, result_id_o}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err_o}, 32'd0);

    for (int i = 0; i < 21; i++) begin
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].id);
      if (vecs[i].resp) begin
        expect_resp($sformatf("vec%0d", i), vecs[i].data, vecs[i].id, vecs[i].lat, 0);
      end else begin
        chk($sformatf("vec%0d_noresp", i), {31'd0, result_valid_o}, 32'd0);
      end
      chk($sformatf("vec%0d_cfg", i), {31'd0, cfg_err_o}, {31'd0, vecs[i].cfg});
    end

    // Back-pressure: response held stable, competing issue refused
    send(SETUP, 32'h00000004, 32'h00000100, 4'h0);
    send(RUN, 32'h01020304, 32'h01010101, 4'h6);
    repeat (2) @(negedge clk_i);
    issue_valid_i = 1'b1; issue_opcode_i = RUN; issue_rs1_i = 32'h7F7F7F7F;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_valid", {31'd0, result_valid_o}, 32'd1);
      chk("bp_data", result_data_o, 32'd10);
      chk("bp_id", {28'd0, result_id_o}, 32'd6);
      chk("bp_ready", {31'd0, issue_ready_o}, 32'd0);
    end
    issue_valid_i = 1'b0;
    expect_resp("bp_end", 32'd10, 4'h6, 0, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      seen = seen | result_valid_o | busy_o;
    end
    chk("bp_not_taken", {31'd0, seen}, 32'd0);

    // Illegal opcode pulses for one cycle with no response
    send(4'b0001, 32'd0, 32'd0, 4'h2);
    chk("illegal_pulse", {31'd0, illegal_o}, 32'd1);
    chk("illegal_noresp", {31'd0, result_valid_o}, 32'd0);
    @(negedge clk_i);
    chk("illegal_clear", {31'd0, illegal_o}, 32'd0);

    // Partial staging discarded by a new SETUP
    do_reset();
    send(SETUP, 32'h00000008, 32'h00000100, 4'h0);
    send(RUN, 32'h7F7F7F7F, 32'h7F7F7F7F, 4'h1);
    expect_resp("part_mid", 32'd0, 4'h1, 0, 0);
    chk("part_busy", {31'd0, busy_o}, 32'd1);
    send(SETUP, 32'h00000004, 32'h00000100, 4'h0);
    chk("part_busy_clr", {31'd0, busy_o}, 32'd0);
    send(RUN, 32'h01020304, 32'h01010101, 4'h2);
    expect_resp("part_final", 32'd10, 4'h2, 2, 0);

    // Reset mid-COMPUTE aborts
    do_reset();
    send(SETUP, 32'h00000010, 32'h00000100, 4'h0);
    for (int w = 0; w < 3; w++) begin
      send(RUN, 32'h01010101, 32'h01010101, 4'h3);
      expect_resp("abort_mid", 32'd0, 4'h3, 0, 0);
    end
    send(RUN, 32'h01010101, 32'h01010101, 4'h4);
    chk("abort_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("abort_valid", {31'd0, result_valid_o}, 32'd0);
    chk("abort_busy0", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    send(RUN, 32'h01020304, 32'h01010101, 4'h5);
    expect_resp("abort_after", 32'd10, 4'h5, 2, 0);

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [7:0] k;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 7))
          0: k = 8'd4;  1: k = 8'd8;  2: k = 8'd16; 3: k = 8'd6;
          4: k = 8'd2;  5: k = 8'd28; 6: k = 8'd0;  default: k = 8'd12;
        endcase
        m_setup({$urandom_range(0, 1048575), 4'($urandom_range(0, 15)), k}, $urandom);
      end else begin
        m_run(4'(9 + $urandom_range(0, 2)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
